// File: rtl/ex_result_buffer_if.sv
// Handshake bundle between the ALU stage, the execute result buffer and the memory/write-back stage.
// The slave modport is the buffer's view; the master modport is the surrounding pipeline's view.
interface ex_result_buffer_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_result;
  logic          in_carry;
  logic [RW-1:0] in_rd;
  logic          in_wb_en;
  logic          in_flag_we;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic          out_carry;
  logic [RW-1:0] out_rd;
  logic          out_wb_en;
  logic          fwd_hit;

  modport slave (
    input  in_valid, in_result, in_carry, in_rd, in_wb_en, in_flag_we, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_rd, out_wb_en, fwd_hit
  );

  modport master (
    output in_valid, in_result, in_carry, in_rd, in_wb_en, in_flag_we, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_rd, out_wb_en, fwd_hit
  );
endinterface

// File: rtl/ex_result_buffer.sv
// Execute-stage two-entry skid buffer with registered ready, head forwarding and C/Z/S flag register.
// Define EX_RESULT_FLAGS_EN to build the flag register; otherwise the flags are tied to 0.
module ex_result_buffer #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  ex_result_buffer_if.slave  bus,
  input  logic               flush,
  output logic               flag_c,
  output logic               flag_z,
  output logic               flag_s
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t          state;
  occ_t          state_n;

  logic [DW-1:0] h_result;
  logic          h_carry;
  logic [RW-1:0] h_rd;
  logic          h_wb_en;

  logic [DW-1:0] s_result;
  logic          s_carry;
  logic [RW-1:0] s_rd;
  logic          s_wb_en;

  logic          rdy;
  logic          h_v;
  logic          acc;
  logic          pop;
  logic          load_h_in;
  logic          load_h_skid;
  logic          load_s;

  assign h_v = (state != EMPTY);
  assign acc = bus.in_valid & rdy;
  assign pop = h_v & bus.out_ready;

  always_comb begin
    state_n     = state;
    load_h_in   = 1'b0;
    load_h_skid = 1'b0;
    load_s      = 1'b0;
    case (state)
      EMPTY: begin
        if (acc) begin
          load_h_in = 1'b1;
          state_n   = ONE;
        end
      end
      ONE: begin
        if (pop) begin
          if (acc) begin
            load_h_in = 1'b1;
          end else begin
            state_n = EMPTY;
          end
        end else if (acc) begin
          load_s  = 1'b1;
          state_n = FULL;
        end
      end
      FULL: begin
        // rdy is low here, so no accept can coincide with the skid drain
        if (pop) begin
          load_h_skid = 1'b1;
          state_n     = ONE;
        end
      end
      default: begin
        state_n = EMPTY;
      end
    endcase
    if (flush) begin
      state_n = EMPTY;
    end
  end

  // Occupancy and ready are both registered; ready mirrors "skid not occupied" next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      rdy   <= 1'b1;
    end else begin
      state <= state_n;
      rdy   <= (state_n != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_result <= '0;
      h_carry  <= 1'b0;
      h_rd     <= '0;
      h_wb_en  <= 1'b0;
    end else if (load_h_in) begin
      h_result <= bus.in_result;
      h_carry  <= bus.in_carry;
      h_rd     <= bus.in_rd;
      h_wb_en  <= bus.in_wb_en;
    end else if (load_h_skid) begin
      h_result <= s_result;
      h_carry  <= s_carry;
      h_rd     <= s_rd;
      h_wb_en  <= s_wb_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_result <= '0;
      s_carry  <= 1'b0;
      s_rd     <= '0;
      s_wb_en  <= 1'b0;
    end else if (load_s) begin
      s_result <= bus.in_result;
      s_carry  <= bus.in_carry;
      s_rd     <= bus.in_rd;
      s_wb_en  <= bus.in_wb_en;
    end
  end

`ifdef EX_RESULT_FLAGS_EN
  // Flags commit at acceptance so the branch unit sees them one cycle after the ALU op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_s <= 1'b0;
    end else if (acc && bus.in_flag_we && !flush) begin
      flag_c <= bus.in_carry;
      flag_z <= (bus.in_result == '0);
      flag_s <= bus.in_result[DW-1];
    end
  end
`else
  logic unused_flag_we;
  assign unused_flag_we = bus.in_flag_we;
  assign flag_c = 1'b0;
  assign flag_z = 1'b0;
  assign flag_s = 1'b0;
`endif

  assign bus.in_ready   = rdy;
  assign bus.out_valid  = h_v;
  assign bus.out_result = h_result;
  assign bus.out_carry  = h_carry;
  assign bus.out_rd     = h_rd;
  assign bus.out_wb_en  = h_wb_en;
  assign bus.fwd_hit    = h_v & h_wb_en & (h_rd != '0);

endmodule

// File: tb/tb_ex_result_buffer.sv
// Randomized and directed bench for ex_result_buffer against a queue-based reference model.
module tb_ex_result_buffer;

  localparam int DW = 32;
  localparam int RW = 5;

  logic clk;
  logic rst_n;
  logic flush;
  logic flag_c;
  logic flag_z;
  logic flag_s;

  ex_result_buffer_if #(.DW(DW), .RW(RW)) bus ();

  ex_result_buffer #(.DW(DW), .RW(RW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .flush  (flush),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .flag_s (flag_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] result;
    logic          carry;
    logic [RW-1:0] rd;
    logic          wb_en;
  } entry_t;

  entry_t q[$];
  logic   mc = 1'b0;
  logic   mz = 1'b0;
  logic   ms = 1'b0;
  int     n_cmp = 0;
  int     n_bad = 0;
  bit     cmp_en = 1'b0;

  function automatic logic fexp(input logic v);
`ifdef EX_RESULT_FLAGS_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: at most two entries in flight, FIFO order, flush empties, flags at acceptance
  always @(posedge clk) begin
    if (rst_n) begin
      automatic bit     m_acc = bus.in_valid && (q.size() < 2);
      automatic bit     m_pop = (q.size() > 0) && bus.out_ready;
      automatic entry_t e;
      if (m_acc && bus.in_flag_we && !flush) begin
        mc = bus.in_carry;
        mz = (bus.in_result == 0);
        ms = bus.in_result[DW-1];
      end
      if (m_pop) void'(q.pop_front());
      if (flush) begin
        q.delete();
      end else if (m_acc) begin
        e.result = bus.in_result;
        e.carry  = bus.in_carry;
        e.rd     = bus.in_rd;
        e.wb_en  = bus.in_wb_en;
        q.push_back(e);
      end
    end
  end

  always @(negedge rst_n) begin
    q.delete();
    mc = 1'b0;
    mz = 1'b0;
    ms = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      check("out_valid", bus.out_valid, q.size() > 0);
      check("in_ready", bus.in_ready, q.size() < 2);
      if (q.size() > 0) begin
        check("out_result", bus.out_result, q[0].result);
        check("out_carry", bus.out_carry, q[0].carry);
        check("out_rd", bus.out_rd, q[0].rd);
        check("out_wb_en", bus.out_wb_en, q[0].wb_en);
        check("fwd_hit", bus.fwd_hit, q[0].wb_en && (q[0].rd != 0));
      end else begin
        check("fwd_hit_idle", bus.fwd_hit, 0);
      end
      check("flag_c", flag_c, fexp(mc));
      check("flag_z", flag_z, fexp(mz));
      check("flag_s", flag_s, fexp(ms));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [DW-1:0] r, input logic c, input logic [RW-1:0] rd,
                     input logic wb, input logic fwe);
    bus.in_valid   = 1'b1;
    bus.in_result  = r;
    bus.in_carry   = c;
    bus.in_rd      = rd;
    bus.in_wb_en   = wb;
    bus.in_flag_we = fwe;
  endtask

  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.in_flag_we = 1'b0;
    flush          = 1'b0;
  endtask

  logic [DW-1:0] vals [4];

  initial begin
    vals[0] = 32'h1;
    vals[1] = 32'h2;
    vals[2] = 32'hFFFF_FFFF;
    vals[3] = 32'h0;
    rst_n         = 1'b0;
    bus.in_result = '0;
    bus.in_carry  = 1'b0;
    bus.in_rd     = '0;
    bus.in_wb_en  = 1'b0;
    bus.out_ready = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_result", bus.out_result, 0);
    check("rst_out_rd", bus.out_rd, 0);
    check("rst_fwd_hit", bus.fwd_hit, 0);
    check("rst_flags", {flag_c, flag_z, flag_s}, 0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    step();

    // Streaming at full rate
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put(vals[i], 1'b0, 5'(i + 1), 1'b1, 1'b0);
      step();
      check("stream_valid", bus.out_valid, 1);
      check("stream_result", bus.out_result, vals[i]);
      check("stream_ready", bus.in_ready, 1);
    end
    idle();
    step();
    check("stream_drained", bus.out_valid, 0);

    // Backpressure into the skid entry
    bus.out_ready = 1'b0;
    put(32'hA, 1'b0, 5'd1, 1'b1, 1'b0);
    step();
    put(32'hB, 1'b0, 5'd2, 1'b1, 1'b0);
    check("bp_ready_before", bus.in_ready, 1);
    step();
    check("bp_ready_low", bus.in_ready, 0);
    check("bp_head_a", bus.out_result, 32'hA);
    put(32'hC, 1'b0, 5'd3, 1'b1, 1'b0);
    step();
    check("bp_head_a_held", bus.out_result, 32'hA);
    check("bp_ready_still_low", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    step();
    check("bp_head_b", bus.out_result, 32'hB);
    check("bp_ready_back", bus.in_ready, 1);
    step();
    check("bp_head_c", bus.out_result, 32'hC);
    idle();
    step();
    check("bp_drained", bus.out_valid, 0);

    // Flag register
    put(32'h0, 1'b1, 5'd4, 1'b1, 1'b1);
    step();
    check("flags_zero_carry", {flag_c, flag_z, flag_s}, {fexp(1), fexp(1), fexp(0)});
    put(32'h8000_0000, 1'b0, 5'd4, 1'b1, 1'b1);
    step();
    check("flags_sign", {flag_c, flag_z, flag_s}, {fexp(0), fexp(0), fexp(1)});
    idle();
    step();

    // Flush with both entries full and a flag-writing entry presented
    bus.out_ready = 1'b0;
    put(32'h11, 1'b0, 5'd3, 1'b1, 1'b0);
    step();
    put(32'h22, 1'b0, 5'd4, 1'b1, 1'b0);
    step();
    check("full_ready", bus.in_ready, 0);
    put(32'h0, 1'b1, 5'd5, 1'b1, 1'b1);
    flush = 1'b1;
    step();
    check("flush_valid", bus.out_valid, 0);
    check("flush_ready", bus.in_ready, 1);
    check("flush_flags", {flag_c, flag_z, flag_s}, {fexp(0), fexp(0), fexp(1)});
    // Accepted-but-flushed entry must not touch the flags
    step();
    check("flush_acc_valid", bus.out_valid, 0);
    check("flush_acc_flags", {flag_c, flag_z, flag_s}, {fexp(0), fexp(0), fexp(1)});
    idle();
    step();

    // Forwarding qualifier
    put(32'h33, 1'b0, 5'd0, 1'b1, 1'b0);
    step();
    check("fwd_rd0", bus.fwd_hit, 0);
    idle();
    bus.out_ready = 1'b1;
    step();
    put(32'h44, 1'b0, 5'd7, 1'b1, 1'b0);
    step();
    check("fwd_rd7", bus.fwd_hit, 1);
    idle();
    step();

    // Asynchronous reset with both entries valid
    bus.out_ready = 1'b0;
    put(32'h55, 1'b1, 5'd7, 1'b1, 1'b1);
    step();
    put(32'h66, 1'b0, 5'd9, 1'b1, 1'b0);
    step();
    idle();
    check("pre_rst_full", {bus.out_valid, bus.in_ready, flag_c}, {1'b1, 1'b0, fexp(1)});
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_fwd_hit", bus.fwd_hit, 0);
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_flags", {flag_c, flag_z, flag_s}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      automatic int sel = $urandom_range(0, 7);
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.in_result  = (sel == 0) ? 32'h0 : (sel == 1) ? 32'h8000_0000 : DW'($urandom);
      bus.in_carry   = 1'($urandom);
      bus.in_rd      = RW'($urandom_range(0, 7));
      bus.in_wb_en   = 1'($urandom);
      bus.in_flag_we = 1'($urandom);
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 31) == 0);
      step();
    end
    idle();
    bus.out_ready = 1'b1;
    repeat (4) step();
    cmp_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
